// File: rtl/fib_scheduler.sv
// fib_scheduler
// Round-robin front end that shares a single Fibonacci engine among NREQ
// requesters. One job is in flight at a time: grant, launch, wait, respond.
// Optional build macro: FIB_SCHED_TIMEOUT_EN bounds the WAIT state to TIMEOUT
// cycles and reports an aborted job with ERR=1 and an all-ones result.
module fib_scheduler #(
   parameter int BITS    = 32,
   parameter int NREQ    = 4,
   parameter int IDW     = $clog2(NREQ),
   parameter int TIMEOUT = 1024
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      REQ_IE,
   input  logic [NREQ*BITS-1:0] REQ_INP,
   output logic [NREQ-1:0]      REQ_ACK,
   output logic [BITS-1:0]      RES_OUT,
   output logic [IDW-1:0]       RES_ID,
   output logic                 RES_OE,
   output logic                 ERR,
   output logic                 BUSY,
   output logic [BITS-1:0]      ENG_INP,
   output logic                 ENG_IE,
   input  logic [BITS-1:0]      ENG_OUT,
   input  logic                 ENG_OE
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;        // first requester considered at the next grant
   logic [IDW-1:0]  job_id;     // requester owning the job in flight
   logic [BITS-1:0] job_n;      // n of the job in flight
   logic [BITS-1:0] job_res;    // result waiting to be presented in RESP

   logic            grant_valid;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  cand;
   logic [BITS-1:0] grant_n;
   logic [IDW-1:0]  ptr_after;
   logic [NREQ-1:0] grant_onehot;

`ifdef FIB_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]   wait_cnt;   // cycles spent in WAIT for the current job
   logic            job_err;    // current job was aborted by the timeout
`else
   // Without the timeout build WAIT is unbounded and no job can fail;
   // TIMEOUT is always positive, so this is a constant 0.
   assign ERR = (TIMEOUT < 0);
`endif

   // Round-robin search: the lowest offset from ptr with a request wins
   // (loop runs from the far end so the nearest candidate is written last).
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      cand        = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (REQ_IE[cand]) begin
            grant_valid = 1'b1;
            grant_id    = cand;
         end
      end
   end

   assign grant_n      = REQ_INP[int'(grant_id)*BITS +: BITS];
   assign ptr_after    = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
   assign grant_onehot = NREQ'(1) << grant_id;

   // Job sequencer: grant in IDLE, pulse the engine, wait for its done
   // pulse, then present the tagged result for one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         ptr      <= '0;
         job_id   <= '0;
         job_n    <= '0;
         job_res  <= '0;
         REQ_ACK  <= '0;
         RES_OUT  <= '0;
         RES_ID   <= '0;
         RES_OE   <= 1'b0;
         BUSY     <= 1'b0;
         ENG_INP  <= '0;
         ENG_IE   <= 1'b0;
`ifdef FIB_SCHED_TIMEOUT_EN
         ERR      <= 1'b0;
         wait_cnt <= '0;
         job_err  <= 1'b0;
`endif
      end else begin
         // pulse outputs default low every cycle
         REQ_ACK <= '0;
         RES_OE  <= 1'b0;
         ENG_IE  <= 1'b0;
`ifdef FIB_SCHED_TIMEOUT_EN
         ERR     <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  REQ_ACK <= grant_onehot;
                  job_id  <= grant_id;
                  job_n   <= grant_n;
                  job_res <= '0;          // n==0 bypasses the engine with result 0
                  ptr     <= ptr_after;
                  BUSY    <= 1'b1;
`ifdef FIB_SCHED_TIMEOUT_EN
                  job_err <= 1'b0;
`endif
                  state   <= (grant_n != '0) ? LAUNCH : RESP;
               end
            end
            LAUNCH: begin
               ENG_IE  <= 1'b1;
               ENG_INP <= job_n;
`ifdef FIB_SCHED_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state   <= WAIT;
            end
            WAIT: begin
               // a done pulse on the limit cycle still counts as success
               if (ENG_OE) begin
                  job_res <= ENG_OUT;
                  state   <= RESP;
               end
`ifdef FIB_SCHED_TIMEOUT_EN
               else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  job_res <= '1;
                  job_err <= 1'b1;
                  state   <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               RES_OE  <= 1'b1;
               RES_OUT <= job_res;
               RES_ID  <= job_id;
`ifdef FIB_SCHED_TIMEOUT_EN
               ERR     <= job_err;
`endif
               BUSY    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fib_scheduler.md
Name: fib_scheduler

Overview:
- Round-robin scheduler that shares one Fibonacci engine among NREQ requesters.
- Accepts one request at a time and launches it on the engine's INP/IE input.
- Waits for the engine's OE, then returns the result tagged with the requester ID.
- Sits between the requester clients and a single Fibonacci instance; replaces per-client engines.

Parameters:
- BITS, 32, width of n and of results (must match the engine's BITS).
- NREQ, 4, number of requesters (>=2).
- IDW, $clog2(NREQ), requester ID width (derived; do not override).
- TIMEOUT, 1024, WAIT-state cycle limit (used only with FIB_SCHED_TIMEOUT_EN).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- REQ_IE  input  NREQ  per-requester request valid, level.
- REQ_INP  input  NREQ*BITS  packed n values; requester i at [i*BITS +: BITS].
- REQ_ACK  output  NREQ  one-hot, one-cycle pulse: request captured.
- RES_OUT  output  BITS  result value.
- RES_ID  output  IDW  requester index for RES_OUT.
- RES_OE  output  1  one-cycle pulse: RES_OUT/RES_ID/ERR valid.
- ERR  output  1  timeout flag, valid with RES_OE.
- BUSY  output  1  high in every state except IDLE.
- ENG_INP  output  BITS  n driven to the engine INP.
- ENG_IE  output  1  one-cycle launch pulse to the engine IE.
- ENG_OUT  input  BITS  engine result.
- ENG_OE  input  1  engine done pulse.

Behaviour:
- Reset (asynchronous) clears all outputs to 0, sets state to IDLE and sets the round-robin pointer ptr to 0. The engine is not reset by this block; the next ENG_IE reloads it.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - REQ_IE is sampled only in this state.
  - If any REQ_IE bit is high, grant the first set bit searching ptr, ptr+1, ... mod NREQ.
  - Capture the winner's n and ID; REQ_ACK[winner]=1 during the next cycle.
  - ptr becomes (winner+1) mod NREQ.
  - Next state is LAUNCH if n!=0, RESP if n==0 (result 0, engine bypassed).
- Requester protocol: hold REQ_IE and REQ_INP stable until REQ_ACK is seen, and drop REQ_IE in the ACK cycle. Re-raising REQ_IE is a new request.
- LAUNCH: ENG_IE=1 and ENG_INP=n for exactly one cycle; next state WAIT.
- WAIT: on ENG_OE=1, capture ENG_OUT into RES_OUT; next state RESP.
- ENG_OE outside WAIT, including same-cycle-as-LAUNCH and post-reset stragglers, is ignored.
- RESP: RES_OE=1 with RES_ID and RES_OUT for one cycle, ERR per the optional feature; next state IDLE.
- Latency:
  - n==0: RES_OE is asserted in the cycle after REQ_ACK.
  - n>=1: ENG_IE is asserted in the cycle after REQ_ACK; RES_OE is asserted the cycle after ENG_OE is sampled.
- Throughput: at least one IDLE cycle between jobs.
- Arithmetic: values pass through unmodified; overflow (mod 2^BITS) is the engine's behaviour.
- RES_OUT holds its value after RES_OE until the next RESP.
- Simultaneous requests are resolved by the pointer only; no priority beyond round-robin.

Optional Feature:
- Macro: FIB_SCHED_TIMEOUT_EN.
- With the macro:
  - A WAIT-cycle counter runs from 0 and clears on entering WAIT.
  - If TIMEOUT cycles elapse without ENG_OE, go to RESP with RES_OUT all-ones and ERR=1.
  - ENG_OE in the same cycle the limit is reached wins: normal result, ERR=0.
  - A late ENG_OE from the aborted job is ignored only if it arrives before the next LAUNCH. Clients must treat the engine as suspect after ERR.
- Without the macro: WAIT is unbounded and ERR is tied 0.

Test Plan:
- Req0 n=10 alone after reset -> REQ_ACK=0001 for 1 cycle; ENG_IE pulse with ENG_INP=10; RES_OUT=55, RES_ID=0, ERR=0, single RES_OE pulse.
- Req0..3 raise together with n=1,2,3,4 -> ACK order 0,1,2,3; results 1,1,2,3 with matching RES_ID; BUSY low only between jobs.
- Req1 and req3 re-request immediately after each ACK, n=5 -> grants alternate 1,3,1,3; every result is 5.
- Req2 n=0 -> no ENG_IE; RES_OE the cycle after ACK with RES_OUT=0, RES_ID=2.
- RST pulsed mid-WAIT (n=20) -> outputs 0 asynchronously; a later ENG_OE is ignored; then req3 and req0 pending -> req0 is granted first (ptr=0).
- With FIB_SCHED_TIMEOUT_EN, TIMEOUT=16, engine OE stuck low -> after 16 WAIT cycles RES_OE with ERR=1, RES_OUT=FFFFFFFF. Without the macro -> BUSY stays high and there is no RES_OE.
